// File: rtl/fifo_arb_pkg.sv
// Shared types and a reference round-robin search used by the fifo_rr_arbiter slice.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } rr_hit_t;

  // Behavioural form of the search that rr_pick implements structurally.
  function automatic rr_hit_t rr_first(input logic [63:0] req, input int unsigned n,
                                       input int unsigned ptr);
    rr_hit_t     r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < 64; k++) begin
      if (k < n && !r.found) begin
        idx = (ptr + k) % n;
        if (req[idx]) begin
          r.found = 1'b1;
          r.idx   = 8'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search of N_REQ requests starting at ptr.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     any_valid
);

  localparam int unsigned PW = $clog2(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [PW-1:0]      off;
  logic [PW:0]        sum;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rot[i-1]) off = PW'(i - 1);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
    winner    = sum[PW-1:0];
    any_valid = |req;
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin N_REQ:1 valid/ready merge with a registered output stage.
// Optional per-owner burst locking is enabled by defining ARB_BURST_LOCK_EN.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(N_REQ)-1:0] out_src
);

  localparam int unsigned PW = $clog2(N_REQ);

  if (N_REQ < 2) begin : g_chk_nreq
    $error("fifo_rr_arbiter: N_REQ must be at least 2");
  end
  if (MAX_BURST < 1) begin : g_chk_burst
    $error("fifo_rr_arbiter: MAX_BURST must be at least 1");
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [PW-1:0]    out_src_q,   out_src_d;
  logic [PW-1:0]    ptr_q,       ptr_d;

  logic             load;
  logic             xfer;
  logic [N_REQ-1:0] pick_req;
  logic [PW-1:0]    winner;
  logic             any_valid;
  logic [WIDTH-1:0] win_data;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
    return (x == PW'(N_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // Reset also gates load so no requester sees ready while the block is held in reset.
  assign load = rst & (~out_valid_q | out_ready);

`ifdef ARB_BURST_LOCK_EN
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  arb_state_t    state_q,    state_d;
  logic [PW-1:0] owner_q,    owner_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  assign pick_req = (state_q == ARB_LOCK) ? (req_valid & (N_REQ'(1) << owner_q)) : req_valid;
`else
  assign pick_req = req_valid;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (pick_req),
    .ptr       (ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign xfer      = load & any_valid;
  assign req_ready = xfer ? (N_REQ'(1) << winner) : '0;

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner == PW'(i)) win_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = win_data;
      out_src_d  = winner;
    end
  end

`ifdef ARB_BURST_LOCK_EN
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    ptr_d      = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (xfer) begin
          if (MAX_BURST == 1) begin
            ptr_d = wrap_inc(winner);
          end else begin
            state_d    = ARB_LOCK;
            owner_d    = winner;
            beat_cnt_d = BW'(1);
          end
        end
      end
      ARB_LOCK: begin
        if (xfer) begin
          if (beat_cnt_q + 1'b1 == BW'(MAX_BURST)) begin
            state_d    = ARB_IDLE;
            beat_cnt_d = '0;
            ptr_d      = wrap_inc(owner_q);
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end else if (load && !req_valid[owner_q]) begin
          // Owner bubble: give up the lock without granting anyone this cycle.
          state_d    = ARB_IDLE;
          beat_cnt_d = '0;
          ptr_d      = wrap_inc(owner_q);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
`else
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = wrap_inc(winner);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
